// File: rtl/adaboost_weight_mem_ctrl.sv
// Weight-table sequencer for an AdaBoost engine: round-robin arbitration between a
// loader (full-table write) and a compute engine (full-table read) over one weight memory.
module adaboost_weight_mem_ctrl #(
    parameter int DEPTH = 30,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_req,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    output logic         load_done,
    input  logic         scan_req,
    output logic         scan_valid,
    output logic [W-1:0] scan_data,
    output logic [4:0]   scan_index,
    output logic         scan_last,
    output logic         busy,
    output logic [4:0]   mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output logic [W-1:0] mem_datain,
    input  logic [W-1:0] mem_dataout
);

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        GNT_LOAD = 1'b0,
        GNT_SCAN = 1'b1
    } grant_t;

    state_t     state_q,      state_d;
    logic [4:0] cnt_q,        cnt_d;
    grant_t     last_gnt_q,   last_gnt_d;
    logic       load_done_q,  load_done_d;
    logic       scan_valid_q, scan_valid_d;
    logic [4:0] scan_index_q, scan_index_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_gnt_q   <= GNT_SCAN;
            load_done_q  <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_index_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_gnt_q   <= last_gnt_d;
            load_done_q  <= load_done_d;
            scan_valid_q <= scan_valid_d;
            scan_index_q <= scan_index_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_gnt_d   = last_gnt_q;
        load_done_d  = 1'b0;
        scan_valid_d = 1'b0;
        scan_index_d = '0;
        load_ready   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_datain   = '0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // On a tie the requester that was not served last wins.
                if (load_req && (!scan_req || last_gnt_q == GNT_SCAN)) begin
                    state_d    = LOAD;
                    last_gnt_d = GNT_LOAD;
                end else if (scan_req) begin
                    state_d    = SCAN;
                    last_gnt_d = GNT_SCAN;
                end
            end

            LOAD: begin
                load_ready  = 1'b1;
                mem_write   = load_valid;
                mem_address = cnt_q;
                mem_datain  = load_data;
                if (load_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            SCAN: begin
                mem_read     = 1'b1;
                mem_address  = cnt_q;
                scan_valid_d = 1'b1;
                scan_index_d = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: weight storage lives outside this block and is deliberately never
    // cleared by reset; only the sequencing state above is reset.
    assign scan_valid = scan_valid_q;
    assign scan_index = scan_index_q;
    assign scan_data  = scan_valid_q ? mem_dataout : '0;
    assign scan_last  = scan_valid_q && (scan_index_q == LAST_IDX);
    assign load_done  = load_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adaboost_weight_mem_ctrl.sv
// Self-checking bench for adaboost_weight_mem_ctrl: behavioural weight memory plus a
// transaction-level reference (expected table contents and round-robin grant history).
module tb_adaboost_weight_mem_ctrl;

    localparam int DEPTH = 30;
    localparam int W     = 9;

    logic         clk;
    logic         rst_n;
    logic         load_req;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         load_done;
    logic         scan_req;
    logic         scan_valid;
    logic [W-1:0] scan_data;
    logic [4:0]   scan_index;
    logic         scan_last;
    logic         busy;
    logic [4:0]   mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_datain;
    logic [W-1:0] mem_dataout;

    logic [W-1:0] mem   [0:31];
    logic [W-1:0] ref_w [0:DEPTH-1];
    bit           last_was_load;
    int           n_checks;
    int           n_fail;

    adaboost_weight_mem_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .scan_req   (scan_req),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .scan_index (scan_index),
        .scan_last  (scan_last),
        .busy       (busy),
        .mem_address(mem_address),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: registered read, zero when not read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_datain;
        mem_dataout <= mem_read ? mem[mem_address] : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("inv_rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
        check("inv_addr_range", {31'd0, mem_address <= 5'(DEPTH - 1)}, 32'd1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, load_ready, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_svalid"}, scan_valid, 0);
        check({tag, "_sdata"}, scan_data, 0);
        check({tag, "_sindex"}, scan_index, 0);
        check({tag, "_slast"}, scan_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_addr"}, mem_address, 0);
        check({tag, "_rd"}, mem_read, 0);
        check({tag, "_wr"}, mem_write, 0);
        check({tag, "_din"}, mem_datain, 0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        load_req   = 1'b0;
        scan_req   = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        cycle();
        cycle();
        check_zero("rst");
        rst_n         = 1'b1;
        last_was_load = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        load_req   = 1'b0;
        scan_req   = 1'b0;
        load_valid = 1'b0;
        repeat (n) begin
            cycle();
            check("idle_busy", busy, 0);
            check("idle_done", load_done, 0);
            check("idle_svalid", scan_valid, 0);
            check("idle_rd", mem_read, 0);
            check("idle_wr", mem_write, 0);
        end
    endtask

    // vmode: 0 always valid, 1 alternating 1/0, 2 random. abort_at<0 means no reset.
    task automatic run_load(input int vmode, input bit ramp, input bit drop, input bit hold,
                            input int abort_at);
        int n;
        int guard;
        bit v;
        logic [W-1:0] d;
        load_req   = 1'b1;
        load_valid = 1'b0;
        #1;
        check("ld_idle_busy", busy, 0);
        check("ld_idle_ready", load_ready, 0);
        check("ld_idle_addr", mem_address, 0);
        cycle();
        n = 0;
        guard = 0;
        while (n < DEPTH && guard < 8 * DEPTH) begin
            if (drop && guard > 0) load_req = 1'b0;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(1, 0));
            endcase
            if (n == abort_at) v = 1'b0;
            d = ramp ? W'(n - 15) : W'($urandom);
            load_valid = v;
            load_data  = d;
            #1;
            check("ld_ready", load_ready, 1);
            check("ld_busy", busy, 1);
            check("ld_wr", mem_write, {31'd0, v});
            check("ld_addr", mem_address, n);
            check("ld_rd", mem_read, 0);
            check("ld_svalid", scan_valid, 0);
            if (n == abort_at) begin
                rst_n      = 1'b0;
                load_req   = 1'b0;
                load_valid = 1'b0;
                cycle();
                check_zero("ld_abort");
                rst_n         = 1'b1;
                last_was_load = 1'b0;
                return;
            end
            if (v) begin
                check("ld_din", mem_datain, d);
                ref_w[n] = d;
                n++;
            end
            cycle();
            guard++;
        end
        check("ld_timeout", n, DEPTH);
        load_valid = 1'b0;
        if (!hold) load_req = 1'b0;
        #1;
        check("ld_done_pulse", load_done, 1);
        check("ld_end_busy", busy, 0);
        check("ld_end_ready", load_ready, 0);
        check("ld_end_wr", mem_write, 0);
    endtask

    task automatic run_scan(input bit drop, input bit hold, input int abort_at);
        scan_req = 1'b1;
        #1;
        check("sc_idle_busy", busy, 0);
        check("sc_idle_rd", mem_read, 0);
        check("sc_idle_addr", mem_address, 0);
        cycle();
        for (int k = 0; k < DEPTH; k++) begin
            if (drop && k > 0) scan_req = 1'b0;
            #1;
            check("sc_rd", mem_read, 1);
            check("sc_wr", mem_write, 0);
            check("sc_addr", mem_address, k);
            check("sc_busy", busy, 1);
            check("sc_ready", load_ready, 0);
            if (k == 0) begin
                check("sc_first_valid", scan_valid, 0);
                check("sc_first_data", scan_data, 0);
            end else begin
                check("sc_valid", scan_valid, 1);
                check("sc_index", scan_index, k - 1);
                check("sc_data", scan_data, ref_w[k-1]);
                check("sc_last", scan_last, 0);
            end
            if (k == abort_at) begin
                rst_n    = 1'b0;
                scan_req = 1'b0;
                cycle();
                check_zero("sc_abort");
                rst_n         = 1'b1;
                last_was_load = 1'b0;
                return;
            end
            cycle();
        end
        #1;
        check("dr_valid", scan_valid, 1);
        check("dr_index", scan_index, DEPTH - 1);
        check("dr_data", scan_data, ref_w[DEPTH-1]);
        check("dr_last", scan_last, 1);
        check("dr_busy", busy, 1);
        check("dr_rd", mem_read, 0);
        if (!hold) scan_req = 1'b0;
        cycle();
        check("sc_end_valid", scan_valid, 0);
        check("sc_end_data", scan_data, 0);
        check("sc_end_index", scan_index, 0);
        check("sc_end_last", scan_last, 0);
        check("sc_end_busy", busy, 0);
    endtask

    // Reference arbiter: serve the single requester, or on a tie the one not served last.
    task automatic run_op(input int vmode, input bit ramp, input bit drop, input bit hold,
                          input int ld_abort, input int sc_abort);
        if (load_req && (!scan_req || !last_was_load)) begin
            last_was_load = 1'b1;
            run_load(vmode, ramp, drop, hold, ld_abort);
        end else if (scan_req) begin
            last_was_load = 1'b0;
            run_scan(drop, hold, sc_abort);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // Ramp load of -15..14, then full scan.
        load_req = 1'b1;
        run_op(0, 1'b1, 1'b0, 1'b0, -1, -1);
        idle_cycles(2);
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);

        // Stalled load with request dropped early, then scan with request dropped.
        load_req = 1'b1;
        run_op(1, 1'b0, 1'b1, 1'b0, -1, -1);
        idle_cycles(1);
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle_cycles(1);

        // Both requests held from reset: grants alternate starting with LOAD.
        do_reset();
        load_req = 1'b1;
        scan_req = 1'b1;
        repeat (4) run_op(2, 1'b0, 1'b0, 1'b1, -1, -1);
        idle_cycles(1);

        // Reset mid-scan at index 12, then a fresh scan from index 0.
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b0, 1'b0, -1, 12);
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);

        // Reset mid-load keeps the written prefix and the older tail.
        load_req = 1'b1;
        run_op(2, 1'b0, 1'b0, 1'b0, 10, -1);
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);

        repeat (8) begin
            int r;
            r = int'($urandom_range(2, 0));
            load_req = (r != 1);
            scan_req = (r != 0);
            run_op(int'($urandom_range(2, 0)), 1'b0, 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), -1, -1);
        end
        idle_cycles(1);
        scan_req = 1'b1;
        run_op(0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
